// File: rtl/glitcher_pkg.sv
// Shared UART receiver constants and state encoding for the glitcher control path.
// Also used by command_processor's UART.
package glitcher_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned PAT_LEN_MAX_DEFAULT  = 4;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, registered byte outputs.
// Also exposes the unregistered stop-bit decision so a consumer can act on the same edge.
module uart_rx_core
  import glitcher_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       byte_done,
  output logic       byte_err,
  output logic [7:0] byte_val
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_s_q;
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            tick;

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          state_d = RX_START;
          cnt_d   = CntHalf;
        end
      end
      RX_START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = RX_IDLE;  // false start
        end else begin
          state_d = RX_DATA;
          cnt_d   = CntFull;
          bit_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = CntFull;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RX_IDLE;
          if (rx_s_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign byte_done = (state_q == RX_STOP) && tick && rx_s_q;
  assign byte_err  = (state_q == RX_STOP) && tick && !rx_s_q;
  assign byte_val  = shift_q;

endmodule

// File: rtl/uart_pattern_trigger.sv
// Passive UART TX tap: matches received bytes against an armed pattern and emits a one-shot
// trigger pulse aligned with the rx_valid of the final matching byte.
module uart_pattern_trigger
  import glitcher_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned PAT_LEN_MAX  = PAT_LEN_MAX_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     arm,
  input  logic [8*PAT_LEN_MAX-1:0] pattern,
  input  logic [2:0]               pattern_len,
  output logic                     armed,
  output logic                     trigger,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic                     frame_err
);

  localparam logic [2:0] LenMax = 3'(PAT_LEN_MAX);

  logic                     byte_done, byte_err;
  logic [7:0]               byte_val;
  logic [8*PAT_LEN_MAX-1:0] pat_q, pat_d;
  logic [2:0]               len_q, len_d;
  logic [2:0]               idx_q, idx_d;
  logic                     armed_q, armed_d;
  logic                     trigger_q, trigger_d;
  logic [7:0]               cur_byte;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .byte_done(byte_done),
    .byte_err (byte_err),
    .byte_val (byte_val)
  );

  always_comb begin
    cur_byte = 8'h00;
    for (int unsigned i = 0; i < PAT_LEN_MAX; i++) begin
      if (idx_q == 3'(i)) cur_byte = pat_q[8*i +: 8];
    end
  end

  // Matcher acts on the stop-bit decision so trigger registers on the same edge as rx_valid.
  always_comb begin
    armed_d   = armed_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    len_d     = len_q;
    trigger_d = 1'b0;
    if (armed_q && byte_done && (len_q != 3'd0)) begin
      if (byte_val == cur_byte) begin
        if (idx_q == len_q - 3'd1) begin
          trigger_d = 1'b1;
          armed_d   = 1'b0;
          idx_d     = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        idx_d = (byte_val == pat_q[7:0]) ? 3'd1 : 3'd0;
      end
    end
    if (byte_err) idx_d = 3'd0;
    if (arm) begin
      armed_d = 1'b1;
      idx_d   = 3'd0;
      pat_d   = pattern;
      len_d   = clamp_len(pattern_len, LenMax);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= 3'd0;
      idx_q     <= 3'd0;
      armed_q   <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      trigger_q <= trigger_d;
    end
  end

  assign armed   = armed_q;
  assign trigger = trigger_q;

endmodule

// File: tb/tb_uart_pattern_trigger.sv
// Directed bench for uart_pattern_trigger: expected receive events are queued as frames are
// driven and checked by a monitor when the DUT reports them.
module tb_uart_pattern_trigger;

  localparam int unsigned CPB = 16;
  localparam int unsigned PLM = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx = 1'b1;
  logic            arm = 1'b0;
  logic [8*PLM-1:0] pattern = '0;
  logic [2:0]      pattern_len = 3'd0;
  logic            armed, trigger, rx_valid, frame_err;
  logic [7:0]      rx_data;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // {is_frame_err, expect_trigger, data}
  logic [9:0] exp_q[$];
  logic [9:0] e;

  uart_pattern_trigger #(
    .CLKS_PER_BIT(CPB),
    .PAT_LEN_MAX (PLM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .arm        (arm),
    .pattern    (pattern),
    .pattern_len(pattern_len),
    .armed      (armed),
    .trigger    (trigger),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic exp_trig);
    exp_q.push_back({~stop, exp_trig, data});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_arm(input logic [31:0] pat, input logic [2:0] len);
    @(negedge clk);
    pattern     = pat;
    pattern_len = len;
    arm         = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, rx_valid, frame_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_err", frame_err, e[9]);
          check("rx_valid", rx_valid, !e[9]);
          if (!e[9]) check("rx_data", rx_data, e[7:0]);
          check("trigger", trigger, e[8]);
        end
      end else if (trigger) begin
        check("stray_trigger", trigger, 1'b0);
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_armed", armed, 1'b0);
    check("reset_trigger", trigger, 1'b0);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: "OK\r\n"
    do_arm(32'h0A0D4B4F, 3'd4);
    check("t1_armed", armed, 1'b1);
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4B, 1'b1, 1'b0);
    send_frame(8'h0D, 1'b1, 1'b0);
    send_frame(8'h0A, 1'b1, 1'b1);
    check("t1_armed_drop", armed, 1'b0);

    // 2: restart path, then one-shot
    do_arm(32'h00004B4F, 3'd2);
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4B, 1'b1, 1'b1);
    check("t2_armed_drop", armed, 1'b0);
    send_frame(8'h4F, 1'b1, 1'b0);
    send_frame(8'h4B, 1'b1, 1'b0);

    // 3: short glitch while idle
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    send_frame(8'h55, 1'b1, 1'b0);

    // 4: frame error clears a partial match
    do_arm(32'h00002211, 3'd2);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("t4_armed_kept", armed, 1'b1);

    // 5: reset mid-frame abandons the byte and disarms
    do_arm(32'h00000041, 3'd1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_armed_after_rst", armed, 1'b0);
    repeat (12 * CPB) @(negedge clk);
    send_frame(8'h41, 1'b1, 1'b0);

    // 6: length 0 never fires; length 7 clamps to 4
    do_arm(32'h00000041, 3'd0);
    send_frame(8'h41, 1'b1, 1'b0);
    check("t6_len0_armed", armed, 1'b1);
    do_arm(32'h44434241, 3'd7);
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h43, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b1);
    check("t6_len7_armed_drop", armed, 1'b0);

    repeat (4 * CPB) @(negedge clk);
    check("pending_events", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
